pixel_fb_writer: RTL

Pixel sink for the line-rasterizer output stream. Accepts (x, y, color) pixels over a valid/ready handshake, clips them against the screen, converts coordinates to a linear framebuffer address and issues single-word writes to the framebuffer memory port over a req/ack handshake. A 4-entry FIFO decouples the rasterizer from memory stalls. `done` marks completion of the primitive.

---
 rtl/pixel_fb_writer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pixel_fb_writer.sv
// Pixel sink: clip (x,y), map to linear address, queue in a 4-entry FIFO, write to framebuffer.
// Latency: accept at edge N -> mem_req high after edge N+1; 1 pixel/cycle sustained with mem_ack high.
// Backpressure: pix_ready low while the FIFO is full; mem_req holds addr/data stable until mem_ack.
module pixel_fb_writer #(
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned ADDR_W  = 19
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               pix_last,
  output logic               mem_req,
  input  logic               mem_ack,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic               busy,
  output logic               done,
  output logic [15:0]        clip_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
    logic               last;
    logic               drop;
  } entry_t;

  typedef enum logic {IDLE, REQ} state_t;

  entry_t     fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  state_t     state;
  state_t     next_state;
  entry_t     in_entry;
  entry_t     head;
  logic       clipped;
  logic       accept;
  logic       push;
  logic       pop;
  logic       done_set;
  logic       next_head_vld;
  logic       next_head_drop;

  assign clipped   = (32'(pix_x) >= H_RES) || (32'(pix_y) >= V_RES);
  assign pix_ready = (count != 3'd4);
  assign accept    = pix_valid && pix_ready;
  // Clipped non-last pixels vanish; a clipped last pixel still travels as a
  // drop marker so done stays ordered behind every earlier write.
  assign push      = accept && (!clipped || pix_last);

  assign head      = fifo_mem[rd_ptr];
  assign mem_req   = (state == REQ);
  assign mem_addr  = head.addr;
  assign mem_wdata = head.color;
  assign busy      = (count != 3'd0) || (state == REQ);

  // The entry that will sit at the head after a pop: the second slot if it
  // holds data, otherwise the pixel being pushed this very cycle.
  assign next_head_vld  = (count >= 3'd2) || push;
  assign next_head_drop = (count >= 3'd2) ? fifo_mem[rd_ptr + 2'd1].drop : clipped;

  // Build the FIFO entry for the incoming pixel.
  always_comb begin
    in_entry = '0;
    if (clipped) begin
      in_entry.last = 1'b1;
      in_entry.drop = 1'b1;
    end else begin
      in_entry.addr  = ADDR_W'(pix_y) * ADDR_W'(H_RES) + ADDR_W'(pix_x);
      in_entry.color = pix_color;
      in_entry.last  = pix_last;
    end
  end

  // FIFO storage, circular pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= in_entry;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of every accepted pixel that fell off screen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip_cnt <= 16'd0;
    end else if (accept && clipped && (clip_cnt != 16'hFFFF)) begin
      clip_cnt <= clip_cnt + 16'd1;
    end
  end

  // Write FSM state register and registered done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= done_set;
    end
  end

  // Write FSM next-state: retire drop markers in IDLE, stream writes in REQ.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        if (count != 3'd0) begin
          if (head.drop) begin
            pop      = 1'b1;
            done_set = head.last;
          end else begin
            next_state = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          pop      = 1'b1;
          done_set = head.last;
          if (next_head_vld && !next_head_drop) next_state = REQ;
          else                                  next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
